cafeteria_id_parser: RTL and testbench

Upstream front end for the cafeteria ID-matching stage. Consumes the puzzle's ingredient-ID section as a raw ASCII byte stream, converts each decimal line into a 50-bit unsigned ID, and emits every ID as two 32-bit words (low word first, then high 18 bits zero-extended). This is exactly the word stream the range-match stage expects on its `data_in`/`valid_in`. It also reports the ID count, a sticky overflow flag, and end-of-stream completion.

---
 rtl/cafeteria_pkg.sv | 25 ++
 rtl/dec_mac10.sv | 21 ++
 rtl/cafeteria_id_parser.sv | 135 +++++++++++++
 tb/tb_cafeteria_id_parser.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cafeteria_pkg.sv
// Constants, ASCII codes and parser states shared by the cafeteria ID and range front ends.
package cafeteria_pkg;

    localparam int ID_W   = 50;
    localparam int WORD_W = 32;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;

    typedef enum logic [1:0] {
        PS_ACCUM    = 2'd0,
        PS_EMIT_LO  = 2'd1,
        PS_EMIT_HI  = 2'd2,
        PS_FINISHED = 2'd3
    } parse_state_t;

    // Plain constants for modules that keep their state register as raw logic.
    localparam logic [1:0] ST_ACCUM    = PS_ACCUM;
    localparam logic [1:0] ST_EMIT_LO  = PS_EMIT_LO;
    localparam logic [1:0] ST_EMIT_HI  = PS_EMIT_HI;
    localparam logic [1:0] ST_FINISHED = PS_FINISHED;

endpackage

// File: rtl/dec_mac10.sv
// Combinational decimal multiply-accumulate: acc*10 + d, truncated to ID_W bits,
// with a flag raised when the exact result no longer fits.
module dec_mac10 #(
    parameter int ID_W = cafeteria_pkg::ID_W
) (
    input  logic [ID_W-1:0] acc_i,
    input  logic [3:0]      digit_i,
    output logic [ID_W-1:0] result_o,
    output logic            ovf_o
);
    import cafeteria_pkg::*;

    logic [ID_W+3:0] wide;

    // Four spare bits are enough because (2^ID_W - 1)*10 + 9 < 2^(ID_W+4).
    assign wide     = ({4'b0000, acc_i} << 3) + ({4'b0000, acc_i} << 1)
                    + {{ID_W{1'b0}}, digit_i};
    assign result_o = wide[ID_W-1:0];
    assign ovf_o    = |wide[ID_W+3:ID_W];

endmodule

// File: rtl/cafeteria_id_parser.sv
// Turns a stream of ASCII decimal lines into ID_W-bit IDs and emits each one
// as a low word followed by a zero-extended high word.
module cafeteria_id_parser #(
    parameter int ID_W   = cafeteria_pkg::ID_W,
    parameter int WORD_W = cafeteria_pkg::WORD_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  id_count,
    output logic              overflow,
    output logic              done
);
    import cafeteria_pkg::*;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   acc_q, acc_d;
    logic [ID_W-1:0]   hold_q, hold_d;
    logic              have_q, have_d;
    logic              end_q, end_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, out_valid_q, done_q;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]   mac_res;
    logic              mac_ovf, accept, is_digit, out_fire;

    dec_mac10 #(.ID_W(ID_W)) u_mac (
        .acc_i   (acc_q),
        .digit_i (in_data[3:0]),
        .result_o(mac_res),
        .ovf_o   (mac_ovf)
    );

    assign accept   = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign is_digit = (in_data >= ASC_0) && (in_data <= ASC_9);

    // A digit carrying in_last still completes its number, so it goes straight to emission.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        hold_d  = hold_q;
        have_d  = have_q;
        end_d   = end_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_d  = mac_res;
                        have_d = 1'b1;
                        if (mac_ovf) ovf_d = 1'b1;
                        if (in_last) begin
                            hold_d  = mac_res;
                            acc_d   = '0;
                            have_d  = 1'b0;
                            end_d   = 1'b1;
                            state_d = ST_EMIT_LO;
                        end
                    end else if (have_q) begin
                        hold_d  = acc_q;
                        acc_d   = '0;
                        have_d  = 1'b0;
                        end_d   = in_last;
                        state_d = ST_EMIT_LO;
                    end else if (in_last) begin
                        state_d = ST_FINISHED;
                    end
                end
            end
            ST_EMIT_LO: begin
                if (out_fire) state_d = ST_EMIT_HI;
            end
            ST_EMIT_HI: begin
                if (out_fire) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = end_q ? ST_FINISHED : ST_ACCUM;
                end
            end
            default: ;
        endcase
    end

    // Output word is loaded from the next state so it is already valid on the delimiter edge.
    always_comb begin
        out_data_d = '0;
        if (state_d == ST_EMIT_LO)      out_data_d = hold_d[WORD_W-1:0];
        else if (state_d == ST_EMIT_HI) out_data_d = WORD_W'(hold_d >> WORD_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            hold_q      <= '0;
            have_q      <= 1'b0;
            end_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            hold_q      <= hold_d;
            have_q      <= have_d;
            end_q       <= end_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ST_ACCUM);
            out_valid_q <= (state_d == ST_EMIT_LO) || (state_d == ST_EMIT_HI);
            done_q      <= (state_d == ST_FINISHED);
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign id_count  = cnt_q;
    assign overflow  = ovf_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cafeteria_id_parser.sv
// Bench for cafeteria_id_parser: directed and random ASCII streams checked
// against a decimal reference model built from plain 64-bit arithmetic.
module tb_cafeteria_id_parser;
    import cafeteria_pkg::*;

    localparam int CNT_W = 16;
    localparam longint unsigned MAX_ID = (64'd1 << ID_W) - 64'd1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        inData = '0;
    logic              inValid = 1'b0;
    logic              inLast = 1'b0;
    logic              inReady;
    logic [WORD_W-1:0] outData;
    logic              outValid;
    logic              outReady = 1'b1;
    logic [CNT_W-1:0]  idCount;
    logic              overflowFlag;
    logic              doneFlag;

    int checks = 0;
    int errors = 0;
    logic [31:0] gotQ[$];
    logic [31:0] expQ[$];
    bit randomBp = 1'b0;

    longint unsigned mAcc = 0;
    bit mHave = 0, mOvf = 0, mDone = 0;
    int unsigned mCount = 0;

    cafeteria_id_parser dut (
        .clk      (clock),
        .rst      (reset),
        .in_data  (inData),
        .in_valid (inValid),
        .in_last  (inLast),
        .in_ready (inReady),
        .out_data (outData),
        .out_valid(outValid),
        .out_ready(outReady),
        .id_count (idCount),
        .overflow (overflowFlag),
        .done     (doneFlag)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Words are recorded on the falling edge, when a handshake is guaranteed for the next rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (outValid && outReady) gotQ.push_back(outData);
            checkOutput("readyValidExclusive", 64'(inReady && outValid), 64'(0));
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] gotWord(input int i);
        if (i < gotQ.size()) return gotQ[i];
        return 'x;
    endfunction

    task automatic modelEmit();
        expQ.push_back(mAcc[31:0]);
        expQ.push_back(32'(mAcc >> 32));
        mCount++;
        mAcc  = 0;
        mHave = 0;
    endtask

    task automatic modelByte(input logic [7:0] b, input bit last);
        longint unsigned exact;
        if (mDone) return;
        if (b >= 8'd48 && b <= 8'd57) begin
            exact = mAcc * 64'd10 + 64'(b - 8'd48);
            if (exact > MAX_ID) mOvf = 1;
            mAcc  = exact % (MAX_ID + 64'd1);
            mHave = 1;
        end else if (mHave) begin
            modelEmit();
        end
        if (last) begin
            if (mHave) modelEmit();
            mDone = 1;
        end
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        inValid = 1'b0;
        inLast = 1'b0;
        outReady = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        checkOutput({tag, ".inReady"},  64'(inReady), 64'(0));
        checkOutput({tag, ".outValid"}, 64'(outValid), 64'(0));
        checkOutput({tag, ".outData"},  64'(outData), 64'(0));
        checkOutput({tag, ".idCount"},  64'(idCount), 64'(0));
        checkOutput({tag, ".overflow"}, 64'(overflowFlag), 64'(0));
        checkOutput({tag, ".done"},     64'(doneFlag), 64'(0));
        reset = 1'b0;
        gotQ.delete();
        expQ.delete();
        mAcc = 0; mHave = 0; mOvf = 0; mDone = 0; mCount = 0;
        #1;
        checkOutput({tag, ".inReadyBeforeEdge"}, 64'(inReady), 64'(0));
        @(posedge clock);
        #2;
        checkOutput({tag, ".inReadyAfterEdge"}, 64'(inReady), 64'(1));
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit last);
        int waitCycles = 0;
        while (!inReady) begin
            if (waitCycles == 300) begin
                checks++;
                errors++;
                $error("[TB] FAIL inReadyWait observed=low expected=high");
                return;
            end
            @(posedge clock);
            #2;
            if (randomBp) outReady = 1'($urandom_range(0, 1));
            waitCycles++;
        end
        inData = b;
        inValid = 1'b1;
        inLast = last;
        @(posedge clock);
        #2;
        inValid = 1'b0;
        inLast = 1'b0;
        modelByte(b, last);
    endtask

    task automatic sendString(input string s, input bit lastOnFinal);
        for (int i = 0; i < s.len(); i++)
            applyStimulus(s[i], lastOnFinal && (i == s.len() - 1));
    endtask

    task automatic drainAndCheck(input string tag);
        int cyc = 0;
        randomBp = 1'b0;
        outReady = 1'b1;
        while (!(gotQ.size() >= expQ.size() && !outValid)) begin
            if (cyc == 300) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s.drain observed=%0d words expected=%0d words", tag, gotQ.size(), expQ.size());
                break;
            end
            @(negedge clock);
            cyc++;
        end
        @(posedge clock);
        #2;
        checkOutput({tag, ".wordCount"}, 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++)
            checkOutput($sformatf("%s.word%0d", tag, i), 64'(gotWord(i)), 64'(expQ[i]));
        checkOutput({tag, ".idCount"},  64'(idCount), 64'(16'(mCount)));
        checkOutput({tag, ".overflow"}, 64'(overflowFlag), 64'(mOvf));
        checkOutput({tag, ".done"},     64'(doneFlag), 64'(mDone));
    endtask

    initial begin
        string crlf, s;
        int len;
        logic [7:0] digit;
        crlf = {8'(ASC_CR), 8'(ASC_LF)};

        applyReset("reset0");

        // Basic value plus the delimiter-to-word timing.
        sendString("123", 1'b0);
        applyStimulus(ASC_LF, 1'b0);
        checkOutput("t123.inReadyT", 64'(inReady), 64'(0));
        checkOutput("t123.outValidT", 64'(outValid), 64'(1));
        checkOutput("t123.loWordT", 64'(outData), 64'h7B);
        @(posedge clock); #2;
        checkOutput("t123.hiWordT1", 64'(outData), 64'h0);
        checkOutput("t123.outValidT1", 64'(outValid), 64'(1));
        @(posedge clock); #2;
        checkOutput("t123.inReadyT2", 64'(inReady), 64'(1));
        checkOutput("t123.outValidT2", 64'(outValid), 64'(0));
        drainAndCheck("t123");
        checkOutput("t123.lo", 64'(gotWord(0)), 64'h0000007B);
        checkOutput("t123.hi", 64'(gotWord(1)), 64'h00000000);
        checkOutput("t123.count", 64'(idCount), 64'(1));
        gotQ.delete(); expQ.delete();

        sendString("1000000000000000\n", 1'b0);
        drainAndCheck("t1e15");
        checkOutput("t1e15.lo", 64'(gotWord(0)), 64'hA4C68000);
        checkOutput("t1e15.hi", 64'(gotWord(1)), 64'h00038D7E);
        gotQ.delete(); expQ.delete();

        sendString("9999999999999999\n", 1'b0);
        drainAndCheck("tOvf");
        checkOutput("tOvf.flag", 64'(overflowFlag), 64'(1));
        checkOutput("tOvf.lo", 64'(gotWord(0)), 64'(32'(64'd9999999999999999 % (MAX_ID + 64'd1))));
        gotQ.delete(); expQ.delete();
        sendString("1\n", 1'b0);
        drainAndCheck("tOvfNext");
        checkOutput("tOvfNext.lo", 64'(gotWord(0)), 64'h1);
        checkOutput("tOvfNext.sticky", 64'(overflowFlag), 64'(1));
        gotQ.delete(); expQ.delete();

        // Backpressure held in the low-word phase.
        outReady = 1'b0;
        sendString("77\n", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #2;
            checkOutput($sformatf("tStall.outValid%0d", i), 64'(outValid), 64'(1));
            checkOutput($sformatf("tStall.outData%0d", i), 64'(outData), 64'd77);
            checkOutput($sformatf("tStall.inReady%0d", i), 64'(inReady), 64'(0));
        end
        drainAndCheck("tStall");
        gotQ.delete(); expQ.delete();

        // Asynchronous reset while the high word is pending.
        outReady = 1'b0;
        sendString("42\n", 1'b0);
        outReady = 1'b1;
        @(posedge clock); #2;
        outReady = 1'b0;
        @(posedge clock); #2;
        checkOutput("tRst.hiPending", 64'(outValid), 64'(1));
        reset = 1'b1;
        #1;
        checkOutput("tRst.outValid", 64'(outValid), 64'(0));
        checkOutput("tRst.outData", 64'(outData), 64'(0));
        checkOutput("tRst.idCount", 64'(idCount), 64'(0));
        checkOutput("tRst.overflow", 64'(overflowFlag), 64'(0));
        applyReset("tRst");
        sendString("42\n", 1'b0);
        drainAndCheck("tRstReplay");
        checkOutput("tRstReplay.lo", 64'(gotWord(0)), 64'h2A);
        checkOutput("tRstReplay.hi", 64'(gotWord(1)), 64'h0);
        checkOutput("tRstReplay.count", 64'(idCount), 64'(1));

        // Blank lines and CRLF, ending with in_last on a digit.
        applyReset("reset2");
        sendString({"\n", crlf, "5", crlf, "7"}, 1'b1);
        checkOutput("tLast.doneEarly", 64'(doneFlag), 64'(0));
        drainAndCheck("tLast");
        checkOutput("tLast.ids", 64'(gotQ.size()), 64'(4));
        checkOutput("tLast.id0", 64'(gotWord(0)), 64'd5);
        checkOutput("tLast.id1", 64'(gotWord(2)), 64'd7);
        inData = 8'h39;
        inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #2;
            checkOutput($sformatf("tLast.inReadyAfter%0d", i), 64'(inReady), 64'(0));
            checkOutput($sformatf("tLast.outValidAfter%0d", i), 64'(outValid), 64'(0));
        end
        inValid = 1'b0;
        checkOutput("tLast.noExtraWords", 64'(gotQ.size()), 64'(4));

        // in_last on a delimiter with nothing pending.
        applyReset("reset3");
        sendString("8\n", 1'b0);
        drainAndCheck("tEmptyLastPre");
        applyStimulus(ASC_LF, 1'b1);
        checkOutput("tEmptyLast.done", 64'(doneFlag), 64'(1));
        drainAndCheck("tEmptyLast");

        // Random numbers, delimiters and backpressure.
        for (int r = 0; r < 3; r++) begin
            applyReset($sformatf("rand%0d", r));
            randomBp = 1'b1;
            for (int n = 0; n < 8; n++) begin
                len = $urandom_range(1, 17);
                s = "";
                for (int k = 0; k < len; k++) begin
                    digit = 8'h30 + 8'($urandom_range(0, 9));
                    s = {s, string'(digit)};
                end
                case ($urandom_range(0, 3))
                    0: s = {s, "\n"};
                    1: s = {s, crlf};
                    2: s = {s, "\n\n"};
                    default: s = {s, " "};
                endcase
                if (n == 7 && (r % 2) == 1) s = s.substr(0, len - 1);
                sendString(s, n == 7);
            end
            drainAndCheck($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
